// File: rtl/add_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : add_seq_ctrl_if
// Brief    : Request/result bus plus 4-bit add-unit link for add_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface add_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int c_W = 4 * NIBBLES;

    // Request side
    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           cin;

    // Result side
    logic           busy;
    logic           done;
    logic [c_W-1:0] sum;
    logic           cout;
    logic           sign;
    logic           zero;
    logic           parity;
    logic           overflow;

    // Shared 4-bit add unit
    logic [3:0]     add_x;
    logic [3:0]     add_y;
    logic           add_cin;
    logic [3:0]     add_z;
    logic           add_carry;
    logic           add_ovf;

    // Requester plus add unit
    modport master (
        output start, a, b, cin,
        output add_z, add_carry, add_ovf,
        input  busy, done, sum, cout, sign, zero, parity, overflow,
        input  add_x, add_y, add_cin
    );

    // Sequencer
    modport slave (
        input  start, a, b, cin,
        input  add_z, add_carry, add_ovf,
        output busy, done, sum, cout, sign, zero, parity, overflow,
        output add_x, add_y, add_cin
    );
endinterface
`default_nettype wire

// File: rtl/add_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : add_seq_ctrl
// Brief    : Nibble-serial W-bit adder sequencer driving a shared 4-bit add
//            unit, with carry chaining and full-width result flags.
// Revision : 1.0 - initial release
// ============================================================================
module add_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    add_seq_ctrl_if.slave  bus
);
    localparam int c_W    = 4 * NIBBLES;
    localparam int c_IDXW = $clog2(NIBBLES);
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(NIBBLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_IDXW-1:0]   r_idx;
    logic [c_W-1:0]      r_a;
    logic [c_W-1:0]      r_b;
    logic                r_cin;
    logic                r_carry;
    logic [c_W-1:0]      r_sum;
    logic                r_cout;
    logic                r_sign;
    logic                r_zero;
    logic                r_parity;
    logic                r_ovf;
    logic                r_done;

    logic                w_accept;
    logic                w_last;
    logic [c_IDXW+1:0]   w_base;
    logic [c_W-1:0]      w_sum_next;
    logic [3:0]          w_add_x;
    logic [3:0]          w_add_y;
    logic                w_add_cin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_RUN;
                    w_accept     = 1'b1;
                end
            end
            S_RUN: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_next = S_IDLE;
                    w_last       = 1'b1;
                end
            end
        endcase
    end

    // Nibble select and the sum as it will look after this edge; the flags on
    // the last nibble must see the final nibble, hence the merged view.
    always_comb begin
        w_base                 = {r_idx, 2'b00};
        w_sum_next             = r_sum;
        w_sum_next[w_base +: 4] = bus.add_z;
        w_add_x                = 4'd0;
        w_add_y                = 4'd0;
        w_add_cin              = 1'b0;
        if (r_state == S_RUN) begin
            w_add_x   = r_a[w_base +: 4];
            w_add_y   = r_b[w_base +: 4];
            w_add_cin = (r_idx == '0) ? r_cin : r_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_cin <= bus.cin;
                r_idx <= '0;
            end
            if (r_state == S_RUN) begin
                r_sum   <= w_sum_next;
                r_carry <= bus.add_carry;
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_idx    <= '0;
                    r_done   <= 1'b1;
                    r_cout   <= bus.add_carry;
                    r_ovf    <= bus.add_ovf;
                    r_sign   <= w_sum_next[c_W-1];
                    r_zero   <= (w_sum_next == '0);
                    r_parity <= ^w_sum_next;
                end
            end
        end
    end

    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = r_done;
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.sign     = r_sign;
    assign bus.zero     = r_zero;
    assign bus.parity   = r_parity;
    assign bus.overflow = r_ovf;
    assign bus.add_x    = w_add_x;
    assign bus.add_y    = w_add_y;
    assign bus.add_cin  = w_add_cin;

endmodule
`default_nettype wire

// File: tb/tb_add_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_seq_ctrl
// Brief    : Self-checking bench for add_seq_ctrl with a behavioural 4-bit
//            add unit and a full-width arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_seq_ctrl;
    localparam int NIBBLES = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        sign;
        logic        zero;
        logic        parity;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        res_t        exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   n_done;

    add_seq_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    add_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit add unit
    always_comb begin
        logic [4:0] t;
        t = {1'b0, bus.add_x} + {1'b0, bus.add_y} + {4'd0, bus.add_cin};
        bus.add_z     = t[3:0];
        bus.add_carry = t[4];
        bus.add_ovf   = (bus.add_x[3] == bus.add_y[3]) && (t[3] != bus.add_x[3]);
    end

    always @(negedge clk) if (bus.done === 1'b1) n_done++;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        res_t r;
        logic [16:0] t;
        t        = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        r.sum    = t[15:0];
        r.cout   = t[16];
        r.sign   = t[15];
        r.zero   = (t[15:0] == 16'd0);
        r.parity = ^t[15:0];
        r.ovf    = (a[15] == b[15]) && (t[15] != a[15]);
        return r;
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic [15:0] s, input logic co, input logic sg,
                                input logic z, input logic p, input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin;
        v.exp.sum = s; v.exp.cout = co; v.exp.sign = sg;
        v.exp.zero = z; v.exp.parity = p; v.exp.ovf = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, ".sum"},      {16'd0, bus.sum},      {16'd0, e.sum});
        chk({tag, ".cout"},     {31'd0, bus.cout},     {31'd0, e.cout});
        chk({tag, ".sign"},     {31'd0, bus.sign},     {31'd0, e.sign});
        chk({tag, ".zero"},     {31'd0, bus.zero},     {31'd0, e.zero});
        chk({tag, ".parity"},   {31'd0, bus.parity},   {31'd0, e.parity});
        chk({tag, ".overflow"}, {31'd0, bus.overflow}, {31'd0, e.ovf});
    endtask

    // Issues one request and returns the number of edges from the start edge
    // until done is observed (bounded).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output int lat);
        bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   lat;
        int   d0;
        int   nb;
        int   k;
        res_t e;
        logic [15:0] ra, rb;
        logic        rc;

        n_cmp = 0; n_err = 0; n_done = 0;
        vecs[0] = mk(16'h1234, 16'h4321, 1'b0, 16'h5555, 0, 0, 0, 0, 0);
        vecs[1] = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 0, 0);
        vecs[2] = mk(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 0, 1, 0, 1, 1);
        vecs[3] = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1, 0, 1, 0, 1);
        vecs[4] = mk(16'h0000, 16'h0000, 1'b1, 16'h0001, 0, 0, 0, 1, 0);
        vecs[5] = mk(16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1, 0, 1, 0, 0);

        rst_n = 1'b0; bus.start = 1'b1; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", {31'd0, bus.busy}, 32'd0);
        chk("rst.done", {31'd0, bus.done}, 32'd0);
        chk_res("rst", '0);
        chk("rst.add_x", {28'd0, bus.add_x}, 32'd0);
        chk("rst.add_y", {28'd0, bus.add_y}, 32'd0);
        chk("rst.add_cin", {31'd0, bus.add_cin}, 32'd0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            chk($sformatf("vec%0d.latency", i), lat, 32'd4);
            chk($sformatf("vec%0d.busy", i), {31'd0, bus.busy}, 32'd0);
            chk_res($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.done_fall", i), {31'd0, bus.done}, 32'd0);
            chk($sformatf("vec%0d.hold", i), {16'd0, bus.sum}, {16'd0, vecs[i].exp.sum});
        end

        // start while busy is ignored
        d0 = n_done;
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        chk("ign.done", {31'd0, bus.done}, 32'd1);
        chk_res("ign", vecs[0].exp);
        repeat (6) @(posedge clk);
        #1;
        chk("ign.pulses", n_done - d0, 32'd1);
        chk("ign.busy", {31'd0, bus.busy}, 32'd0);

        // reset while idx==2
        d0 = n_done;
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mrst.busy", {31'd0, bus.busy}, 32'd0);
        chk("mrst.done", {31'd0, bus.done}, 32'd0);
        chk_res("mrst", '0);
        repeat (6) @(posedge clk);
        #1;
        chk("mrst.pulses", n_done - d0, 32'd0);
        do_op(16'h0F0F, 16'h00F1, 1'b0, lat);
        chk("mrst2.latency", lat, 32'd4);
        chk_res("mrst2", model(16'h0F0F, 16'h00F1, 1'b0));
        chk("mrst2.sum_const", {16'd0, bus.sum}, 32'h1000);
        @(posedge clk); #1;

        // start held across done: back-to-back
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 16'h4444; bus.b = 16'h0101;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b.latency1", lat, 32'd4);
        chk_res("b2b1", model(16'h1111, 16'h2222, 1'b0));
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b.busy_rise", {31'd0, bus.busy}, 32'd1);
        chk("b2b.done_fall", {31'd0, bus.done}, 32'd0);
        nb = 0; k = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            if (bus.busy === 1'b1) nb++;
            @(posedge clk); #1;
            k++;
        end
        chk("b2b.busy_cycles", nb, 32'd4);
        chk_res("b2b2", model(16'h4444, 16'h0101, 1'b0));

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rb = ~ra;
                1: ra = 16'h7FFF;
                default: ;
            endcase
            e = model(ra, rb, rc);
            do_op(ra, rb, rc, lat);
            chk($sformatf("rnd%0d.latency", i), lat, 32'd4);
            chk_res($sformatf("rnd%0d", i), e);
            k = $urandom_range(1, 3);
            repeat (k) @(posedge clk);
            #1;
            chk($sformatf("rnd%0d.hold", i), {16'd0, bus.sum}, {16'd0, e.sum});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
